// File: rtl/pipelined_adder.sv
// Streaming ripple-carry adder: WIDTH-bit operands added CHUNK bits per pipeline stage,
// valid/ready on both sides. Define ADDER_OVERFLOW_EN to add the o_Overflow output.
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_Cin,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [WIDTH-1:0] o_Sum,
`ifdef ADDER_OVERFLOW_EN
  output logic             o_Overflow,
`endif
  output logic             o_Cout
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  logic advance;

  // The whole pipeline moves in lockstep; bubbles are never squeezed out.
  assign advance = !o_Valid || i_Ready;
  assign o_Ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IN_W  = WIDTH - k * CHUNK;  // operand bits not yet added
    localparam int SUM_W = (k + 1) * CHUNK;    // sum bits complete after this stage

    logic [IN_W-1:0]  in_a;
    logic [IN_W-1:0]  in_b;
    logic             in_vld;
    logic             in_cry;
    logic [CHUNK:0]   part;
    logic [SUM_W-1:0] sum_in;
    logic             vld_d, vld_q;
    logic             cry_d, cry_q;
    logic [SUM_W-1:0] sum_d, sum_q;

    if (k == 0) begin : g_src
      assign in_a   = i_A;
      assign in_b   = i_B;
      assign in_vld = i_Valid;
      assign in_cry = i_Cin;
      assign sum_in = part[CHUNK-1:0];
    end else begin : g_src
      assign in_a   = g_stage[k-1].g_skew.a_q;
      assign in_b   = g_stage[k-1].g_skew.b_q;
      assign in_vld = g_stage[k-1].vld_q;
      assign in_cry = g_stage[k-1].cry_q;
      assign sum_in = {part[CHUNK-1:0], g_stage[k-1].sum_q};
    end

    always_comb begin
      part  = {1'b0, in_a[CHUNK-1:0]} + {1'b0, in_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, in_cry};
      // NOTE: every output of this block gets a default first, so no path leaves a latch.
      vld_d = vld_q;
      cry_d = cry_q;
      sum_d = sum_q;
      if (advance) begin
        vld_d = in_vld;
        cry_d = part[CHUNK];
        sum_d = sum_in;
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
        vld_q <= 1'b0;
        cry_q <= 1'b0;
        sum_q <= '0;
      end else begin
        vld_q <= vld_d;
        cry_q <= cry_d;
        sum_q <= sum_d;
      end
    end

    // Skew registers carry the operand chunks that later stages still have to add.
    if (k < LAST) begin : g_skew
      logic [IN_W-CHUNK-1:0] a_d, a_q;
      logic [IN_W-CHUNK-1:0] b_d, b_q;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (advance) begin
          a_d = in_a[IN_W-1:CHUNK];
          b_d = in_b[IN_W-1:CHUNK];
        end
      end

      always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign o_Valid = g_stage[LAST].vld_q;
  assign o_Sum   = g_stage[LAST].sum_q;
  assign o_Cout  = g_stage[LAST].cry_q;

`ifdef ADDER_OVERFLOW_EN
  logic msb_cin;
  logic ovf_d, ovf_q;

  always_comb begin
    // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
    msb_cin = g_stage[LAST].part[CHUNK-1] ^ g_stage[LAST].in_a[CHUNK-1]
            ^ g_stage[LAST].in_b[CHUNK-1];
    ovf_d = ovf_q;
    if (advance) ovf_d = msb_cin ^ g_stage[LAST].part[CHUNK];
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign o_Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vector table, streaming, backpressure,
// random traffic against a queue model, mid-stream reset and an exhaustive 4-bit regression.
`timescale 1ns/1ps
module tb_pipelined_adder;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int STAGES = WIDTH / CHUNK;

  logic        clk;
  logic        rst;
  logic        i_valid, o_ready, o_valid, i_ready;
  logic [15:0] a, b, o_sum;
  logic        cin, o_cout;
`ifdef ADDER_OVERFLOW_EN
  logic        o_ovf;
  logic        r_ovf;
`endif

  logic        r_valid, r_oready, r_ovalid, r_ready;
  logic [3:0]  r_a, r_b, r_sum;
  logic        r_cin, r_cout;

  pipelined_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(i_valid), .o_Ready(o_ready),
    .i_A(a), .i_B(b), .i_Cin(cin), .o_Valid(o_valid), .i_Ready(i_ready),
    .o_Sum(o_sum),
`ifdef ADDER_OVERFLOW_EN
    .o_Overflow(o_ovf),
`endif
    .o_Cout(o_cout)
  );

  pipelined_adder #(.WIDTH(4), .CHUNK(1)) dut_r (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(r_valid), .o_Ready(r_oready),
    .i_A(r_a), .i_B(r_b), .i_Cin(r_cin), .o_Valid(r_ovalid), .i_Ready(r_ready),
    .o_Sum(r_sum),
`ifdef ADDER_OVERFLOW_EN
    .o_Overflow(r_ovf),
`endif
    .o_Cout(r_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t        vecs[8];
  int          n_cmp, n_bad;
  logic [17:0] exp_q[$];
  int          n_out, n_in;
  logic        acc_flag;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: plain unsigned and signed integer arithmetic, {ovf, cout, sum}.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
    int          sx, sy, s;
    logic [16:0] u;
    logic        ovf;
    u   = 17'(x) + 17'(y) + 17'(c);
    sx  = int'($signed(x));
    sy  = int'($signed(y));
    s   = sx + sy + int'(c);
    ovf = 1'b0;
`ifdef ADDER_OVERFLOW_EN
    ovf = (s > 32767) || (s < -32768);
`endif
    return {ovf, u};
  endfunction

  function automatic logic [17:0] dut_res();
`ifdef ADDER_OVERFLOW_EN
    return {o_ovf, o_cout, o_sum};
`else
    return {1'b0, o_cout, o_sum};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle with scoreboard bookkeeping: handshakes are sampled mid-cycle.
  task automatic step();
    logic [17:0] e;
    #2;
    if (o_valid && i_ready) begin
      n_out++;
      if (exp_q.size() == 0) check("spurious_result", 32'(exp_q.size()), 1);
      else begin
        e = exp_q.pop_front();
        check("result", 32'(dut_res()), 32'(e));
      end
    end
    acc_flag = i_valid && o_ready;
    if (acc_flag) begin
      exp_q.push_back(model(a, b, cin));
      n_in++;
    end
    tick();
  endtask

  task automatic apply_vec(input vec_t v);
    a = v.a; b = v.b; cin = v.cin; i_valid = 1'b1; i_ready = 1'b1;
    check("vec_in_ready", 32'(o_ready), 1);
    tick();
    i_valid = 1'b0;
    for (int j = 0; j < STAGES - 1; j++) begin
      check("vec_latency_early", 32'(o_valid), 0);
      tick();
    end
    check("vec_valid", 32'(o_valid), 1);
    check("vec_sum", 32'(o_sum), 32'(v.sum));
    check("vec_cout", 32'(o_cout), 32'(v.cout));
`ifdef ADDER_OVERFLOW_EN
    check("vec_ovf", 32'(o_ovf), 32'(v.ovf));
`endif
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k, guard;
    logic [15:0] bp_a[8], bp_b[8];
    logic [8:0]  w;
    int          ea;

    n_cmp = 0; n_bad = 0; n_out = 0; n_in = 0; acc_flag = 1'b0;
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    r_valid = 1'b0; r_ready = 1'b1; r_a = '0; r_b = '0; r_cin = 1'b0;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[7] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};

    // Reset state
    tick();
    check("rst_valid", 32'(o_valid), 0);
    check("rst_sum", 32'(o_sum), 0);
    check("rst_cout", 32'(o_cout), 0);
    check("rst_ready", 32'(o_ready), 1);
    check("rst_r_valid", 32'(r_ovalid), 0);
`ifdef ADDER_OVERFLOW_EN
    check("rst_ovf", 32'(o_ovf), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed single beats with latency
    for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

    // Streaming: A=B=i, Cin=1, back to back
    i_ready = 1'b1;
    for (int c = 0; c < STAGES - 1 + 8; c++) begin
      if (c < 8) begin
        a = 16'(c + 1); b = 16'(c + 1); cin = 1'b1; i_valid = 1'b1;
      end else i_valid = 1'b0;
      tick();
      if (c >= STAGES - 1) begin
        check("stream_valid", 32'(o_valid), 1);
        check("stream_res", 32'(dut_res()), 32'(2 * (c - (STAGES - 1) + 1) + 1));
      end
    end
    i_valid = 1'b0;
    tick();
    check("stream_end_idle", 32'(o_valid), 0);

    // Backpressure: producer holds an unaccepted beat
    for (int i = 0; i < 8; i++) begin
      bp_a[i] = 16'($urandom);
      bp_b[i] = 16'($urandom);
    end
    exp_q.delete(); n_out = 0; n_in = 0;
    i_ready = 1'b0; k = 0; guard = 0;
    while (!o_valid && guard < 20) begin
      a = bp_a[k]; b = bp_b[k]; cin = 1'(k & 1); i_valid = 1'b1;
      step();
      if (acc_flag) k++;
      guard++;
    end
    check("bp_first_valid", 32'(o_valid), 1);
    for (int j = 0; j < 5; j++) begin
      a = bp_a[k]; b = bp_b[k]; cin = 1'(k & 1); i_valid = 1'b1;
      check("bp_ready_low", 32'(o_ready), 0);
      check("bp_hold", 32'(dut_res()), 32'(exp_q[0]));
      step();
      if (acc_flag) k++;
    end
    i_ready = 1'b1; guard = 0;
    while ((k < 8 || exp_q.size() != 0) && guard < 50) begin
      if (k < 8) begin
        a = bp_a[k]; b = bp_b[k]; cin = 1'(k & 1); i_valid = 1'b1;
      end else i_valid = 1'b0;
      step();
      if (acc_flag) k++;
      guard++;
    end
    i_valid = 1'b0;
    check("bp_count", 32'(n_out), 8);
    check("bp_drained", 32'(exp_q.size()), 0);

    // Random traffic on both sides
    n_out = 0; n_in = 0;
    for (int c = 0; c < 400; c++) begin
      if (!i_valid && $urandom_range(0, 9) < 7) begin
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); i_valid = 1'b1;
      end
      i_ready = ($urandom_range(0, 3) != 0);
      step();
      if (acc_flag) i_valid = 1'b0;
    end
    i_valid = 1'b0; i_ready = 1'b1; guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      step();
      guard++;
    end
    check("rand_drained", 32'(exp_q.size()), 0);
    check("rand_count", 32'(n_out), 32'(n_in));

    // Reset with three beats in flight
    i_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      a = 16'(j + 16'h0100); b = 16'h00FF; cin = 1'b1; i_valid = 1'b1;
      step();
    end
    i_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(o_valid), 0);
    check("midrst_sum", 32'(o_sum), 0);
    check("midrst_cout", 32'(o_cout), 0);
    check("midrst_ready", 32'(o_ready), 1);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int j = 0; j < 6; j++) begin
      check("midrst_no_stale", 32'(o_valid), 0);
      tick();
    end
    apply_vec(vecs[2]);

    // Exhaustive 4-bit regression, CHUNK=1 (latency 4)
    r_ready = 1'b1;
    for (int c = 0; c < 512 + 3; c++) begin
      if (c < 512) begin
        w = 9'(c);
        r_a = w[8:5]; r_b = w[4:1]; r_cin = w[0]; r_valid = 1'b1;
      end else r_valid = 1'b0;
      tick();
      if (c >= 3) begin
        w  = 9'(c - 3);
        ea = int'(w[8:5]) + int'(w[4:1]) + int'(w[0]);
        check("reg4_result", 32'({r_ovalid, r_cout, r_sum}), 32'({1'b1, 5'(ea)}));
      end else check("reg4_latency", 32'(r_ovalid), 0);
    end
    r_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
